serial_loader: RTL and testbench
================================

SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 The block SHALL have parameter: WIDTH, 8, parallel word width in bits (>= 2).
REQ-002 The block SHALL have parameter: MSB_FIRST, 1, 1 = first accepted bit lands in d[WIDTH-1]; 0 = first bit lands in d[0].
REQ-003 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port: rst  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port: start  input  1  request to begin collecting one word.
REQ-006 The block SHALL have port: sin_data  input  1  serial data bit.
REQ-007 The block SHALL have port: sin_valid  input  1  sin_data is valid this cycle.
REQ-008 The block SHALL have port: d  output  WIDTH  assembled word, drives the downstream register d input.
REQ-009 The block SHALL have port: en  output  1  one-cycle load strobe, drives the downstream register en input.
REQ-010 The block SHALL have port: busy  output  1  high in every state except IDLE.
REQ-011 The block SHALL have port: err  output  1  one-cycle parity error pulse (tied 0 when parity is compiled out).

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, PARITY and LOAD; PARITY SHALL exist only when SERIAL_LOADER_PARITY_EN is defined.
REQ-013 In IDLE, start=1 SHALL move the FSM to SHIFT and clear the bit counter and shift register; sin_valid in IDLE SHALL be ignored.
REQ-014 In SHIFT, each cycle with sin_valid=1 SHALL accept one bit and increment the counter; cycles with sin_valid=0 SHALL hold all state (gaps allowed).
REQ-015 Bit order SHALL follow MSB_FIRST; after WIDTH accepted bits the word SHALL be complete.
REQ-016 On the cycle the WIDTH-th bit is accepted, the FSM SHALL move to PARITY if enabled, else to LOAD.
REQ-017 In LOAD, en SHALL be 1 for exactly one cycle and d SHALL present the complete word in that same cycle; the FSM SHALL then return to IDLE.
REQ-018 Latency SHALL be: en high in the cycle immediately after the last data bit is accepted (parity off), or after the parity bit is accepted (parity on).
REQ-019 d SHALL update only on entry to LOAD and SHALL hold its value between loads.
REQ-020 start while busy=1 SHALL be ignored; a start in the same cycle as the LOAD cycle SHALL also be ignored.
REQ-021 The counter SHALL be sized ceil(log2(WIDTH+1)) bits and SHALL never wrap; excess sin_valid bits after completion SHALL be ignored until the next start.

Reset
REQ-022 rst=0 SHALL immediately, without waiting for clk, force the FSM to IDLE and set d=0, en=0, busy=0, err=0 and the counter to 0.
REQ-023 Reset asserted mid-word SHALL discard the partial word; no en pulse SHALL follow reset release.
REQ-024 After rst returns to 1, the first accepted start SHALL be taken on the next rising edge with start=1.

Configuration
REQ-025 Macro SERIAL_LOADER_PARITY_EN SHALL compile in even-parity checking: after WIDTH data bits, the next sin_valid bit is the parity bit; if the XOR of data and parity bits is 0, the FSM SHALL go to LOAD; otherwise err SHALL pulse for one cycle, d SHALL be unchanged, no en SHALL occur, and the FSM SHALL return to IDLE.
REQ-026 Without SERIAL_LOADER_PARITY_EN, no parity bit SHALL be consumed, the PARITY state SHALL not exist, and err SHALL be constant 0.

Verification
REQ-027 WIDTH=8, MSB_FIRST=1: start, then bits 0,0,0,1,1,1,1,1 on consecutive cycles -> one-cycle en with d=31 on the next cycle; busy low afterward.
REQ-028 MSB_FIRST=0: bits 1,1,1,1,1,1,1,0 with sin_valid gaps of 2 cycles between bits -> en once with d=127; d holds 127 until the next load.
REQ-029 Start at the fourth accepted bit of a word (busy=1) -> ignored; the word completes normally with a single en pulse.
REQ-030 rst pulled low after 5 of 8 bits of the word 100 -> d=0 and busy=0 immediately; no en after release; the next full word 12 loads d=12.
REQ-031 With SERIAL_LOADER_PARITY_EN: word 31 with parity bit 1 -> en, d=31; word 12 with parity bit 1 -> err pulse, no en, d stays 31.

Source files
------------

// File: rtl/serial_loader.sv
// Serial-to-parallel loader: collects WIDTH serial bits and presents them with a one-cycle load strobe.
// Define SERIAL_LOADER_PARITY_EN to add a trailing even-parity bit check (err pulse on mismatch).
module serial_loader #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin_data,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] d,
  output logic             en,
  output logic             busy,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SERIAL_LOADER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, LOAD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LOAD = 2'd3} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_next;

  // Handshake: a bit is accepted on a rising edge where state is SHIFT (or PARITY) and
  // sin_valid=1; start is accepted only on an edge where state is IDLE.
  always_comb begin
    if (MSB_FIRST != 0) sh_next = {sh[WIDTH-2:0], sin_data};
    else                sh_next = {sin_data, sh[WIDTH-1:1]};
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      d     <= '0;
      en    <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      en  <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            cnt   <= '0;
            sh    <= '0;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (sin_valid) begin
            sh  <= sh_next;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
`ifdef SERIAL_LOADER_PARITY_EN
              state <= PARITY;
`else
              state <= LOAD;
              d     <= sh_next;
              en    <= 1'b1;
`endif
            end
          end
        end
`ifdef SERIAL_LOADER_PARITY_EN
        PARITY: begin
          if (sin_valid) begin
            // Even parity: data bits plus parity bit must XOR to zero.
            if (^{sh, sin_data} == 1'b0) begin
              state <= LOAD;
              d     <= sh;
              en    <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
        end
`endif
        LOAD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_loader.sv
// Bench for serial_loader: two instances (MSB-first and LSB-first) share stimulus; table vectors,
// corner-case sequences and random words are checked against an expected-word scoreboard.
module tb_serial_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       sin_data = 1'b0;
  logic       sin_valid = 1'b0;
  logic [7:0] d_m, d_l;
  logic       en_m, en_l, busy_m, busy_l, err_m, err_l;
  logic [1:0] dbg_m, dbg_l;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_lq[$];
  logic [7:0] last_m = 8'd0;
  logic [7:0] last_l = 8'd0;

  serial_loader #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .start(start), .sin_data(sin_data), .sin_valid(sin_valid),
    .d(d_m), .en(en_m), .busy(busy_m), .err(err_m), .dbg_state(dbg_m)
  );

  serial_loader #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .start(start), .sin_data(sin_data), .sin_valid(sin_valid),
    .d(d_l), .en(en_l), .busy(busy_l), .err(err_l), .dbg_state(dbg_l)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: the k-th bit sent is seq[7-k]; it lands at weight 7-k (MSB first) or k (LSB first).
  function automatic logic [7:0] ref_word(input logic [7:0] seq, input bit msb);
    int v;
    v = 0;
    for (int k = 0; k < 8; k++)
      if (seq[7-k]) v += msb ? (1 << (7 - k)) : (1 << k);
    return v[7:0];
  endfunction

  // Scoreboard: every load strobe must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (en_m) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL mon_en_m: got pulse want none (d=%0d)", d_m);
      end else check("mon_d_m", d_m, exp_q.pop_front());
    end
    if (en_l) begin
      if (exp_lq.size() == 0) begin
        total++; bad++;
        $display("FAIL mon_en_l: got pulse want none (d=%0d)", d_l);
      end else check("mon_d_l", d_l, exp_lq.pop_front());
    end
  end

  // Sends one framed word; returns in the cycle right after the final accepted bit.
  task automatic send_word(input logic [7:0] seq, input int gap, input int start_at,
                           input logic bad_par, input logic [7:0] em, input logic [7:0] el,
                           input string nm);
    start = 1'b1; sin_valid = 1'b0;
    cyc();
    start = 1'b0;
    check({nm, "_busy_start"}, busy_m, 1'b1);
    for (int k = 0; k < 8; k++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      if (k > 0) repeat (g) begin
        sin_valid = 1'b0; sin_data = 1'($urandom_range(0, 1));
        cyc();
      end
      sin_valid = 1'b1; sin_data = seq[7-k]; start = (k == start_at);
      cyc();
      start = 1'b0;
    end
    sin_valid = 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
    check({nm, "_en_before_par"}, en_m, 1'b0);
    sin_valid = 1'b1; sin_data = (^seq) ^ bad_par;
    if (!bad_par) begin
      exp_q.push_back(em); exp_lq.push_back(el);
    end
    cyc();
    sin_valid = 1'b0;
    if (bad_par) begin
      check({nm, "_err"}, err_m, 1'b1);
      check({nm, "_en_err"}, en_m, 1'b0);
      check({nm, "_busy_err"}, busy_m, 1'b0);
      check({nm, "_d_m_keep"}, d_m, last_m);
      check({nm, "_d_l_keep"}, d_l, last_l);
    end else begin
      check({nm, "_en_m"}, en_m, 1'b1);
      check({nm, "_d_m"}, d_m, em);
      check({nm, "_d_l"}, d_l, el);
      last_m = em; last_l = el;
    end
`else
    check({nm, "_bad_par_unused"}, {31'd0, bad_par}, 32'd0);
    exp_q.push_back(em); exp_lq.push_back(el);
    check({nm, "_en_m"}, en_m, 1'b1);
    check({nm, "_en_l"}, en_l, 1'b1);
    check({nm, "_d_m"}, d_m, em);
    check({nm, "_d_l"}, d_l, el);
    check({nm, "_err"}, err_m, 1'b0);
    last_m = em; last_l = el;
`endif
  endtask

  typedef struct {
    logic [7:0] seq;
    int         gap;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'b0001_1111, 0, 8'd31,  8'd248};
    vecs[1] = '{8'b1111_1110, 2, 8'd254, 8'd127};
    vecs[2] = '{8'hA5,        1, 8'hA5,  8'hA5};
    vecs[3] = '{8'h01,        0, 8'h01,  8'h80};
    vecs[4] = '{8'h00,        3, 8'h00,  8'h00};
    vecs[5] = '{8'hFF,        0, 8'hFF,  8'hFF};
    vecs[6] = '{8'h0C,        1, 8'h0C,  8'h30};

    // Reset state
    #3;
    check("rst_d", d_m, 8'd0);
    check("rst_en", en_m, 1'b0);
    check("rst_busy", busy_m, 1'b0);
    check("rst_err", err_m, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // sin_valid in IDLE is ignored
    sin_valid = 1'b1; sin_data = 1'b1;
    repeat (3) cyc();
    sin_valid = 1'b0;
    check("idle_bits_busy", busy_m, 1'b0);
    check("idle_bits_d", d_m, 8'd0);

    for (int i = 0; i < 7; i++) begin
      send_word(vecs[i].seq, vecs[i].gap, -1, 1'b0, vecs[i].exp_m, vecs[i].exp_l,
                $sformatf("vec%0d", i));
      cyc();
      check($sformatf("vec%0d_en_off", i), en_m, 1'b0);
      check($sformatf("vec%0d_busy_off", i), busy_m, 1'b0);
      // Excess valid bits after completion are ignored and d holds
      sin_valid = 1'b1;
      repeat (3) begin sin_data = 1'($urandom_range(0, 1)); cyc(); end
      sin_valid = 1'b0;
      check($sformatf("vec%0d_hold_m", i), d_m, vecs[i].exp_m);
      check($sformatf("vec%0d_hold_l", i), d_l, vecs[i].exp_l);
      check($sformatf("vec%0d_idle", i), busy_l, 1'b0);
    end

    // Start while busy (at the fourth accepted bit) is ignored
    send_word(8'h3C, 0, 3, 1'b0, 8'h3C, 8'h3C, "start_busy");
    // Start in the LOAD cycle is ignored
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("start_in_load_busy", busy_m, 1'b0);
    cyc();
    check("start_in_load_idle", busy_m, 1'b0);

    // Reset mid-word after 5 of 8 bits of 100
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sin_valid = 1'b1; sin_data = ((8'd100 >> (7 - k)) & 8'd1) != 0;
      cyc();
    end
    sin_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_d", d_m, 8'd0);
    check("midrst_busy", busy_m, 1'b0);
    check("midrst_en", en_m, 1'b0);
    last_m = 8'd0; last_l = 8'd0;
    @(negedge clk);
    rst = 1'b1;
    sin_valid = 1'b1;
    repeat (4) begin sin_data = 1'($urandom_range(0, 1)); cyc(); end
    sin_valid = 1'b0;
    check("postrst_busy", busy_m, 1'b0);
    send_word(8'd12, 0, -1, 1'b0, 8'd12, 8'h30, "postrst12");
    cyc();

`ifdef SERIAL_LOADER_PARITY_EN
    send_word(8'd31, 0, -1, 1'b0, 8'd31, 8'd248, "par_ok31");
    cyc();
    send_word(8'd12, 0, -1, 1'b1, 8'd12, 8'h30, "par_bad12");
    cyc();
    check("par_err_clear", err_m, 1'b0);
    check("par_d_stays31", d_m, 8'd31);
`endif

    // Random words against the reference model
    for (int n = 0; n < 30; n++) begin
      logic [7:0] s;
      logic       bp;
      s  = 8'($urandom_range(0, 255));
`ifdef SERIAL_LOADER_PARITY_EN
      bp = ($urandom_range(0, 3) == 0);
`else
      bp = 1'b0;
`endif
      send_word(s, -1, int'($urandom_range(0, 11)), bp, ref_word(s, 1'b1), ref_word(s, 1'b0),
                $sformatf("rnd%0d", n));
      repeat ($urandom_range(1, 3)) begin
        sin_valid = 1'($urandom_range(0, 1)); sin_data = 1'($urandom_range(0, 1));
        cyc();
      end
      sin_valid = 1'b0;
      check($sformatf("rnd%0d_idle", n), busy_m, 1'b0);
      check($sformatf("rnd%0d_d_m", n), d_m, last_m);
    end

    cyc();
    check("sb_drained_m", exp_q.size(), 0);
    check("sb_drained_l", exp_lq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
